// File: rtl/oled_page_streamer.sv
// oled_page_streamer
// Walks a 128x64 monochrome framebuffer page by page with column-mode reads
// and emits an SSD1306/SH1106-style byte stream (page/column address
// commands followed by column data bytes) on a valid/ready interface with a
// D/C flag. One accepted start produces one full-screen refresh.
//
// Optional build macro OLED_AUTO_REFRESH_EN: when defined, a down-counter
// retriggers a frame every REFRESH_CYCLES clocks while idle. When it is not
// defined, frames start only on the start input.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | waiting for start (or auto-refresh), stream idle
// S_CMD_PAGE   | presenting 0xB0|page, dc=0
// S_CMD_COLL   | presenting 0x00|COL_OFFSET[3:0], dc=0
// S_CMD_COLH   | presenting 0x10|COL_OFFSET[7:4], dc=0
// S_RD_ISSUE   | fb_re high for one cycle at (col, page*8)
// S_RD_CAPTURE | fb_dout valid; bit-reverse it into the stream register
// S_DATA       | data byte presented (dc=1) until it transfers
// S_DONE       | one-cycle done pulse, busy low

module oled_page_streamer #(
   parameter int H_PIXELS       = 128,
   parameter int PAGES          = 8,
   parameter int COL_OFFSET     = 0,
   parameter int REFRESH_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       fb_re,
   output logic [7:0] fb_xpos,
   output logic [7:0] fb_ypos,
   output logic       fb_rmode,
   input  logic [7:0] fb_dout,
   output logic [7:0] m_data,
   output logic       m_dc,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_last
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD_PAGE,
      S_CMD_COLL,
      S_CMD_COLH,
      S_RD_ISSUE,
      S_RD_CAPTURE,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [7:0] COL_LAST  = 8'(H_PIXELS - 1);
   localparam logic [7:0] PAGE_LAST = 8'(PAGES - 1);
   localparam logic [7:0] COL_OFF   = 8'(COL_OFFSET);

   state_t     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] col_q, col_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       fb_re_q, fb_re_d;
   logic [7:0] fb_xpos_q, fb_xpos_d;
   logic [7:0] fb_ypos_q, fb_ypos_d;
   logic [7:0] m_data_q, m_data_d;
   logic       m_dc_q, m_dc_d;
   logic       m_valid_q, m_valid_d;
   logic       m_last_q, m_last_d;

   logic       xfer;
   logic       frame_go;
   logic [7:0] fb_rev;

   // A byte moves whenever the registered valid meets the transport's ready.
   assign xfer = m_valid_q && m_ready;

`ifdef OLED_AUTO_REFRESH_EN
   localparam logic [31:0] REFRESH_LOAD = 32'(REFRESH_CYCLES - 1);

   logic [31:0] refresh_cnt_q, refresh_cnt_d;
   logic        auto_go;

   assign auto_go  = (refresh_cnt_q == 32'd0);
   assign frame_go = start || auto_go;

   // Refresh timer: reload at every frame start, otherwise count down to 0 and park.
   always_comb begin
      refresh_cnt_d = refresh_cnt_q;
      if (state_q == S_IDLE && frame_go) begin
         refresh_cnt_d = REFRESH_LOAD;
      end else if (refresh_cnt_q != 32'd0) begin
         refresh_cnt_d = refresh_cnt_q - 32'd1;
      end
   end

   // Refresh timer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt_q <= REFRESH_LOAD;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
      end
   end
`else
   assign frame_go = start;
`endif

   // Framebuffer packs the top row in bit7; the panel wants the top row in bit0.
   always_comb begin
      fb_rev = 8'h00;
      for (int i = 0; i < 8; i++) begin
         fb_rev[i] = fb_dout[7 - i];
      end
   end

   // Next-state and next-output logic for the page walker.
   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      col_d     = col_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      fb_re_d   = 1'b0;
      m_data_d  = m_data_q;
      m_dc_d    = m_dc_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;

      case (state_q)
         S_IDLE: begin
            if (frame_go) begin
               page_d    = 8'd0;
               col_d     = 8'd0;
               busy_d    = 1'b1;
               m_data_d  = 8'hB0;
               m_dc_d    = 1'b0;
               m_valid_d = 1'b1;
               m_last_d  = 1'b0;
               state_d   = S_CMD_PAGE;
            end
         end

         S_CMD_PAGE: begin
            if (xfer) begin
               m_data_d = {4'h0, COL_OFF[3:0]};
               state_d  = S_CMD_COLL;
            end
         end

         S_CMD_COLL: begin
            if (xfer) begin
               m_data_d = {4'h1, COL_OFF[7:4]};
               state_d  = S_CMD_COLH;
            end
         end

         S_CMD_COLH: begin
            if (xfer) begin
               m_valid_d = 1'b0;
               fb_re_d   = 1'b1;
               state_d   = S_RD_ISSUE;
            end
         end

         S_RD_ISSUE: begin
            state_d = S_RD_CAPTURE;
         end

         S_RD_CAPTURE: begin
            m_data_d  = fb_rev;
            m_dc_d    = 1'b1;
            m_valid_d = 1'b1;
            m_last_d  = (page_q == PAGE_LAST) && (col_q == COL_LAST);
            state_d   = S_DATA;
         end

         S_DATA: begin
            if (xfer) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (col_q < COL_LAST) begin
                  col_d   = col_q + 8'd1;
                  fb_re_d = 1'b1;
                  state_d = S_RD_ISSUE;
               end else if (page_q < PAGE_LAST) begin
                  // Next page starts straight away with its page command.
                  page_d    = page_q + 8'd1;
                  col_d     = 8'd0;
                  m_data_d  = {4'hB, page_d[3:0]};
                  m_dc_d    = 1'b0;
                  m_valid_d = 1'b1;
                  state_d   = S_CMD_PAGE;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Read address tracks the counters; page*8 is a plain shift.
      fb_xpos_d = col_d;
      fb_ypos_d = {page_d[4:0], 3'b000};
   end

   // State and registered outputs; rst returns everything to idle and drops any pending byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         page_q    <= 8'd0;
         col_q     <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fb_re_q   <= 1'b0;
         fb_xpos_q <= 8'd0;
         fb_ypos_q <= 8'd0;
         m_data_q  <= 8'd0;
         m_dc_q    <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         page_q    <= page_d;
         col_q     <= col_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fb_re_q   <= fb_re_d;
         fb_xpos_q <= fb_xpos_d;
         fb_ypos_q <= fb_ypos_d;
         m_data_q  <= m_data_d;
         m_dc_q    <= m_dc_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign fb_re    = fb_re_q;
   assign fb_xpos  = fb_xpos_q;
   assign fb_ypos  = fb_ypos_q;
   assign fb_rmode = 1'b1;
   assign m_data   = m_data_q;
   assign m_dc     = m_dc_q;
   assign m_valid  = m_valid_q;
   assign m_last   = m_last_q;

endmodule

// File: doc/oled_page_streamer.md
Name: oled_page_streamer

Overview:
- Downstream consumer of the monochrome 128x64 framebuffer; walks the buffer page by page using column-mode reads (8 vertical pixels per read).
- Emits an SSD1306/SH1106-style byte stream: per-page address commands, then column data bytes. Output is a valid/ready stream with a D/C flag, feeding the SPI/I2C OLED transport.
- One start request produces one full-screen refresh.

Parameters:
- H_PIXELS, 128: columns per page; column counter range 0..H_PIXELS-1.
- PAGES, 8: pages per frame; each page is 8 rows.
- COL_OFFSET, 0: start column sent in the column-address commands; use 2 for SH1106.
- REFRESH_CYCLES, 1000000: auto-refresh period in clk cycles; used only with OLED_AUTO_REFRESH_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle frame request; ignored while busy
- busy  out  1  high from accepted start until frame completes
- done  out  1  one-cycle pulse at frame completion
- fb_re  out  1  framebuffer read enable
- fb_xpos  out  8  read x = current column
- fb_ypos  out  8  read y = page*8
- fb_rmode  out  1  constant 1 (column read)
- fb_dout  in  8  framebuffer data, valid the cycle after fb_re; bit7 = row fb_ypos, bit0 = row fb_ypos+7
- m_data  out  8  stream byte
- m_dc  out  1  0 = command, 1 = display data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from transport
- m_last  out  1  high with the final byte of the frame

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: busy=0, done=0, fb_re=0, fb_xpos=0, fb_ypos=0, m_data=0, m_dc=0, m_valid=0, m_last=0. Page and column counters clear; FSM goes to IDLE.
- Transfer rule: a byte transfers on any cycle with m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_dc and m_last hold stable.
  - m_valid never drops without a transfer, except on rst.
- FSM states:
  - IDLE: on start, clear page/column, set busy=1, go to CMD_PAGE.
  - CMD_PAGE: present 0xB0|page with dc=0; on transfer go to CMD_COLL.
  - CMD_COLL: present 0x00|COL_OFFSET[3:0] with dc=0; on transfer go to CMD_COLH.
  - CMD_COLH: present 0x10|COL_OFFSET[7:4] with dc=0; on transfer go to RD_ISSUE.
  - RD_ISSUE: fb_re=1 for exactly one cycle with fb_xpos=col and fb_ypos=page*8; go to RD_CAPTURE.
  - RD_CAPTURE: m_data <= bit-reverse(fb_dout), so that bit0 = top row; dc=1, m_valid=1; go to DATA.
  - DATA: hold until transfer, then:
    - if col < H_PIXELS-1: col++, go to RD_ISSUE;
    - else if page < PAGES-1: page++, col=0, go to CMD_PAGE;
    - else go to DONE.
  - DONE: done=1 and busy=0 for one cycle; go to IDLE.
- Sequencing: reads are strictly serialized, with no prefetch. Minimum of 3 cycles per data byte with m_ready held high.
- Frame length: PAGES*(3+H_PIXELS) transfers, which is 1048 at the defaults.
- m_last: high only on the last data byte (page PAGES-1, col H_PIXELS-1).
- Boundaries:
  - start while busy is ignored.
  - start and rst in the same cycle: rst wins.
  - rst mid-frame: all outputs return to reset values at the next edge and any pending byte is dropped. The transport must tolerate a truncated stream.
  - Counter arithmetic is unsigned. page*8 uses a shift, so fb_ypos maxes at 56. Counters never wrap within a frame.

Optional Feature:
- Macro: OLED_AUTO_REFRESH_EN.
- When defined:
  - A 32-bit down-counter loads REFRESH_CYCLES-1 on reset and at each frame start.
  - It decrements every cycle and saturates at 0.
  - At 0 in IDLE it triggers a frame exactly as start does.
  - start still works and also reloads the counter.
- When not defined: frames begin only on start; REFRESH_CYCLES is unused and no counter logic exists.

Test Plan:
- Reset: assert rst for 2 cycles -> all outputs 0; busy=0; no m_valid for 10 cycles without start.
- Single pixel: fb model with only (0,0) set, m_ready=1, pulse start -> first four transfers are 0xB0/dc0, 0x00/dc0, 0x10/dc0, 0x01/dc1; then 127 bytes of 0x00; then 0xB1. 1048 transfers total, m_last on the 1048th, done pulse the cycle after, busy low.
- Corner pixel: only (127,63) set -> final transfer 0x80 with dc=1 and m_last=1; every other data byte 0x00.
- Backpressure: m_ready pseudo-random at 50% with a checkerboard image (0xAA columns) -> byte sequence identical to the m_ready=1 run; m_data stable in every stalled cycle; fb_re pulses exactly 1024 times.
- Offset/collision: build with COL_OFFSET=2 -> column commands 0x02 and 0x10. Start pulsed while busy -> no restart; still exactly 1048 transfers.
- Reset mid-frame: rst at transfer 500 -> m_valid=0 next cycle. A new start emits 0xB0 first and a full 1048-byte frame. With OLED_AUTO_REFRESH_EN and REFRESH_CYCLES=5000, frames start every 5000 cycles without start.
